// File: rtl/flash_ctrl_pkg.sv
// Shared types, default timing and helpers for the NOR flash read controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package flash_ctrl_pkg;

  // Default geometry and timing, in core clock cycles
  localparam int DEF_ADDR_W    = 22;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_BURST_MAX = 8;
  localparam int DEF_CE_WAIT   = 5;
  localparam int DEF_OE_WAIT   = 6;
  localparam int DEF_PAGE_WAIT = 2;
  localparam int DEF_IDLE_TO   = 15;
  localparam int DEF_CNT_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CE_WAIT,
    S_OE_WAIT,
    S_CAPTURE,
    S_PAGE,
    S_HOLD
  } fc_state_t;

  // A zero-length request still reads one word; long requests are capped at one page
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/fc_wait_timer.sv
// Down-counter shared by every timed state of the flash read FSM.
// Latency: done rises load_val cycles after the load edge (load_val=0 -> done next cycle).
// Backpressure: none; load always wins over counting.
module fc_wait_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/flash_read_ctrl.sv
// Read-only burst controller for an asynchronous parallel NOR flash with programmable wait states.
// Latency: first word CE_WAIT+OE_WAIT+3 cycles after fire from IDLE, OE_WAIT+2 from HOLD; then every PAGE_WAIT+1.
// Backpressure: req_ready low while a request is in flight; read data has no backpressure.
module flash_read_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int CE_WAIT   = DEF_CE_WAIT,
  parameter int OE_WAIT   = DEF_OE_WAIT,
  parameter int PAGE_WAIT = DEF_PAGE_WAIT,
  parameter int IDLE_TO   = DEF_IDLE_TO,
  parameter int CNT_W     = DEF_CNT_W,
  localparam int LEN_W    = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic [ADDR_W-1:0] fl_addr,
  input  logic [DATA_W-1:0] fl_data_in,
  output logic              fl_ce_n,
  output logic              fl_oe_n,
  output logic              fl_we_n
);

  fc_state_t        state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] len_clamped;
  logic             fire;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  assign req_ready   = (state == S_IDLE) || (state == S_HOLD);
  assign busy        = (state != S_IDLE);
  assign fire        = req_valid && req_ready;
  assign fl_we_n     = 1'b1;
  assign len_clamped = LEN_W'(clamp_len(int'(req_len), BURST_MAX));

  // Reload the timer on the edge that enters each timed state, mirroring the FSM exits below
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(CE_WAIT - 1);
      end
      S_CE_WAIT: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(OE_WAIT - 1);
        end
      end
      S_CAPTURE: begin
        tmr_load = 1'b1;
        tmr_val  = (remaining > LEN_W'(1)) ? CNT_W'(PAGE_WAIT - 1) : CNT_W'(IDLE_TO - 1);
      end
      S_HOLD: begin
        if (fire) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(OE_WAIT - 1);
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  fc_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Sequencing FSM with registered flash pins and read-return outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fl_ce_n   <= 1'b1;
      fl_oe_n   <= 1'b1;
      fl_addr   <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          fl_ce_n <= 1'b1;
          fl_oe_n <= 1'b1;
          if (fire) begin
            fl_addr   <= req_addr;
            remaining <= len_clamped;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Address has had one cycle to settle before the chip is selected
          fl_ce_n <= 1'b0;
          state   <= S_CE_WAIT;
        end
        S_CE_WAIT: begin
          if (tmr_done) begin
            fl_oe_n <= 1'b0;
            state   <= S_OE_WAIT;
          end
        end
        S_OE_WAIT: begin
          if (tmr_done) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rd_data   <= fl_data_in;
          rd_valid  <= 1'b1;
          rd_last   <= (remaining == LEN_W'(1));
          remaining <= remaining - LEN_W'(1);
          if (remaining > LEN_W'(1)) begin
            fl_addr <= fl_addr + ADDR_W'(1);
            state   <= S_PAGE;
          end else begin
            state <= S_HOLD;
          end
        end
        S_PAGE: begin
          if (tmr_done) state <= S_CAPTURE;
        end
        S_HOLD: begin
          // A new request wins over the release timeout; the chip stays selected
          if (fire) begin
            fl_addr   <= req_addr;
            remaining <= len_clamped;
            state     <= S_OE_WAIT;
          end else if (tmr_done) begin
            fl_ce_n <= 1'b1;
            fl_oe_n <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          fl_ce_n <= 1'b1;
          fl_oe_n <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/flash_read_ctrl.md
Name: flash_read_ctrl

Overview:
Parametrised read-only controller for an asynchronous parallel NOR flash, used by the digit recogniser to fetch weights and images. It accepts (address, length) burst requests over a valid/ready handshake and drives the flash CE/OE/WE/address pins with programmable wait states. In page mode it returns up to BURST_MAX consecutive words. It keeps the chip selected for a programmable hold window, so a follow-up request skips the CE setup delay.

Parameters:
ADDR_W, 22, flash word-address width
DATA_W, 16, flash data width
BURST_MAX, 8, maximum words per request
CE_WAIT, 5, cycles from CE low to OE low (first access)
OE_WAIT, 6, cycles from OE low (or new address in HOLD) to capture
PAGE_WAIT, 2, cycles from address increment to capture within a burst
IDLE_TO, 15, cycles CE/OE remain low in HOLD before release
CNT_W, 4, wait-timer width; every *_WAIT and IDLE_TO must be in 1..2^CNT_W-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request offered
req_ready  out  1  controller can accept a request (IDLE or HOLD)
req_addr  in  ADDR_W  start word address
req_len  in  $clog2(BURST_MAX+1)  word count; 0 treated as 1, >BURST_MAX clamped to BURST_MAX
rd_valid  out  1  one-cycle pulse per returned word; no backpressure
rd_data  out  DATA_W  returned word, valid when rd_valid
rd_last  out  1  high with rd_valid on the final word of a request
busy  out  1  high in every state except IDLE
fl_addr  out  ADDR_W  flash address pins (registered)
fl_data_in  in  DATA_W  flash data pins
fl_ce_n  out  1  chip enable, active low
fl_oe_n  out  1  output enable, active low
fl_we_n  out  1  write enable; constant 1

Behaviour:
- Reset values: state IDLE; fl_ce_n=1, fl_oe_n=1, fl_we_n=1; fl_addr=0; rd_valid=0, rd_last=0, rd_data=0; busy=0; req_ready=1.
- A request fires on req_valid & req_ready. On fire, addr and clamped len are latched into fl_addr and the remaining counter.
- IDLE: CE_n=1, OE_n=1. On fire -> SETUP.
- SETUP (1 cycle): CE_n=1 with the address stable. -> CE_WAIT.
- CE_WAIT: CE_n=0, OE_n=1 for CE_WAIT cycles. -> OE_WAIT.
- OE_WAIT: CE_n=0, OE_n=0 for OE_WAIT cycles. -> CAPTURE.
- CAPTURE (1 cycle): fl_data_in is registered into rd_data. rd_valid pulses the following cycle; rd_last=1 if remaining==1. Remaining decrements.
  - If remaining>1: -> PAGE, with fl_addr incremented in the same edge.
  - Otherwise: -> HOLD.
- PAGE: CE_n=0, OE_n=0 for PAGE_WAIT cycles. -> CAPTURE.
- HOLD: CE_n=0, OE_n=0, req_ready=1.
  - On fire: latch new address and length -> OE_WAIT. The CE delay is skipped.
  - After IDLE_TO cycles with no fire: -> IDLE. CE_n and OE_n go high on that edge.
- Latency from a fire at cycle T to the first rd_valid:
  - From IDLE: T+CE_WAIT+OE_WAIT+3, which is T+14 with defaults.
  - From HOLD: T+OE_WAIT+2, which is T+8.
  - Subsequent burst words arrive every PAGE_WAIT+1 cycles (3 with defaults).
- req_ready is 0 in SETUP, CE_WAIT, OE_WAIT, CAPTURE and PAGE. Requests offered in those states are held off, not dropped.
- fl_addr increments modulo 2^ADDR_W; a burst starting at all-ones wraps to 0.
- A fire in the same cycle that the HOLD timer expires is accepted; HOLD takes priority and the block does not enter IDLE.
- Reset mid-operation: on the next edge CE_n/OE_n go high and state is IDLE. No further rd_valid is emitted for the aborted request.
- The wait timer reloads on every state entry and counts down to its done flag. No path through the state machine takes zero cycles.

Decomposition:
- Package flash_ctrl_pkg holds:
  - the state enum fc_state_t (IDLE, SETUP, CE_WAIT, OE_WAIT, CAPTURE, PAGE, HOLD);
  - default timing constants;
  - the function clamp_len.
- One sub-module, fc_wait_timer: a CNT_W-bit synchronous active-high-reset down-counter with load, load_val and done outputs. It is shared by all timed states.

Test Plan:
- Single read from IDLE: fire addr=0x000100, len=1 at T -> fl_ce_n falls at T+2, fl_oe_n falls at T+7. rd_valid with rd_last=1 at T+14 carries the model word for 0x100. CE_n/OE_n rise 15 cycles after HOLD entry.
- Burst: addr=0x3FFFFE, len=4 -> fl_addr runs 3FFFFE, 3FFFFF, 000000, 000001. rd_valid arrives at T+14, 17, 20, 23; rd_last only on the last.
- Clamping: len=0 -> one word returned; len=12 -> exactly 8 words, rd_last on the 8th.
- HOLD reuse: second fire addr=0x20 five cycles after the first burst ends -> fl_ce_n stays 0 throughout. rd_valid at fire+8.
- Boundary: a fire on the HOLD timeout cycle is accepted with no CE_n glitch. A request held during a burst waits with req_ready=0 and is accepted on HOLD entry.
- Reset mid-OE_WAIT: rst=1 for one cycle -> next edge CE_n=1, OE_n=1, busy=0. No rd_valid follows; a new request then completes normally.
